wb_switch_n: RTL and testbench

- Parametrised single-master Wishbone classic interconnect, one master to NUM_SLAVES slaves. Successor to the fixed 4-slave switch in the coprocessor tops.
- Address decode is region-based. Each of NUM_REGIONS address/mask windows maps to a slave index, so one slave can own several windows (e.g. ROM at reset vector and at high memory).
- Adds a registered decode stage, an internal default slave (error or ack), a per-access bus timeout with error response, and a sticky error-capture register for debug and test pins.

---
 rtl/wb_pkg.sv | 23 ++
 rtl/wb_region_decode.sv | 33 +++
 rtl/wb_switch_n.sv | 177 +++++++++++++++++
 tb/tb_wb_switch_n.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone interconnect blocks.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DFLT = 2'd2
  } wb_state_t;

  localparam int IDX_W = 4;
  localparam logic [31:0] DEFAULT_DATA_PAT = 32'hAAAAAAAA;

  // Widest address the window-match helper handles; callers size-cast into it.
  localparam int MATCH_W = 64;

  // An address falls in a window when every masked bit equals the base.
  function automatic logic wb_addr_match(input logic [MATCH_W-1:0] adr,
                                         input logic [MATCH_W-1:0] base,
                                         input logic [MATCH_W-1:0] mask);
    return ((adr ^ base) & mask) == '0;
  endfunction

endpackage

// File: rtl/wb_region_decode.sv
// Combinational region decoder: address -> per-window hits, winning slave index.
module wb_region_decode
  import wb_pkg::*;
#(
  parameter int NUM_SLAVES  = 4,
  parameter int NUM_REGIONS = 4,
  parameter int AW          = 32,
  parameter logic [NUM_REGIONS*AW-1:0]    REGION_ADDR  = '0,
  parameter logic [NUM_REGIONS*AW-1:0]    REGION_MASK  = '0,
  parameter logic [NUM_REGIONS*IDX_W-1:0] REGION_SLAVE = '0
) (
  input  logic [AW-1:0]          m_adr_i,
  output logic [NUM_REGIONS-1:0] hit,
  output logic [IDX_W-1:0]       slave_idx,
  output logic                   unmapped
);

  // Evaluate every window, then let the lowest-numbered hit choose the slave.
  always_comb begin
    hit       = '0;
    slave_idx = '0;
    for (int r = 0; r < NUM_REGIONS; r++) begin
      hit[r] = wb_addr_match(MATCH_W'(m_adr_i),
                             MATCH_W'(REGION_ADDR[r*AW +: AW]),
                             MATCH_W'(REGION_MASK[r*AW +: AW]));
    end
    for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
      if (hit[r]) slave_idx = REGION_SLAVE[r*IDX_W +: IDX_W];
    end
    unmapped = !(|hit) || (int'(slave_idx) >= NUM_SLAVES);
  end

endmodule

// File: rtl/wb_switch_n.sv
// Single-master Wishbone classic switch to NUM_SLAVES slaves with registered
// decode, default slave, ack timeout and sticky error capture.
//
// state | meaning
// IDLE  | waiting for cyc&stb; decodes the address (one cycle latency)
// BUSY  | routed to the registered slave; waits for ack/err or timeout
// DFLT  | one-cycle internal response for an unmapped address
module wb_switch_n
  import wb_pkg::*;
#(
  parameter int NUM_SLAVES     = 4,
  parameter int NUM_REGIONS    = 4,
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter logic [NUM_REGIONS*AW-1:0]    REGION_ADDR  = '0,
  parameter logic [NUM_REGIONS*AW-1:0]    REGION_MASK  = '0,
  parameter logic [NUM_REGIONS*IDX_W-1:0] REGION_SLAVE = '0,
  parameter int TIMEOUT_CYCLES = 256,
  parameter bit DEFAULT_ACK    = 1'b0,
  parameter logic [DW-1:0] DEFAULT_DATA = DW'(DEFAULT_DATA_PAT)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AW-1:0]              m_adr_i,
  input  logic [DW-1:0]              m_dat_i,
  output logic [DW-1:0]              m_dat_o,
  input  logic [DW/8-1:0]            m_sel_i,
  input  logic                       m_we_i,
  input  logic                       m_cyc_i,
  input  logic                       m_stb_i,
  output logic                       m_ack_o,
  output logic                       m_err_o,
  output logic [NUM_SLAVES*AW-1:0]   s_adr_o,
  output logic [NUM_SLAVES*DW-1:0]   s_dat_o,
  output logic [NUM_SLAVES*(DW/8)-1:0] s_sel_o,
  output logic [NUM_SLAVES-1:0]      s_we_o,
  output logic [NUM_SLAVES-1:0]      s_cyc_o,
  output logic [NUM_SLAVES-1:0]      s_stb_o,
  input  logic [NUM_SLAVES*DW-1:0]   s_dat_i,
  input  logic [NUM_SLAVES-1:0]      s_ack_i,
  input  logic [NUM_SLAVES-1:0]      s_err_i,
  output logic                       err_valid_o,
  output logic [AW-1:0]              err_adr_o,
  output logic                       err_timeout_o,
  input  logic                       err_clr_i
);

  localparam int TC_M1 = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam int TW    = (TC_M1 > 0) ? $clog2(TC_M1 + 1) : 1;

  wb_state_t              state_q, state_d;
  logic [IDX_W-1:0]       idx_q;
  logic [TW-1:0]          tmo_cnt;
  logic [NUM_REGIONS-1:0] dec_hit;
  logic [IDX_W-1:0]       dec_idx;
  logic                   dec_unmapped;
  logic                   dec_mapped;
  logic [NUM_SLAVES-1:0]  sel_oh;
  logic                   ack_sel, err_sel;
  logic [DW-1:0]          dat_sel;
  logic                   timeout_hit;
  logic                   tmo_fire;
  logic                   start;

  wb_region_decode #(
    .NUM_SLAVES  (NUM_SLAVES),
    .NUM_REGIONS (NUM_REGIONS),
    .AW          (AW),
    .REGION_ADDR (REGION_ADDR),
    .REGION_MASK (REGION_MASK),
    .REGION_SLAVE(REGION_SLAVE)
  ) u_decode (
    .m_adr_i  (m_adr_i),
    .hit      (dec_hit),
    .slave_idx(dec_idx),
    .unmapped (dec_unmapped)
  );

  assign dec_mapped  = (|dec_hit) && !dec_unmapped;
  assign start       = (state_q == IDLE) && m_cyc_i && m_stb_i;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TW'(TC_M1));

  // Master request fields go to every slave unregistered.
  assign s_adr_o = {NUM_SLAVES{m_adr_i}};
  assign s_dat_o = {NUM_SLAVES{m_dat_i}};
  assign s_sel_o = {NUM_SLAVES{m_sel_i}};
  assign s_we_o  = {NUM_SLAVES{m_we_i}};

  // One-hot view of the registered target and its response mux.
  always_comb begin
    sel_oh  = '0;
    dat_sel = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      sel_oh[s] = (idx_q == IDX_W'(s));
      if (sel_oh[s]) dat_sel = s_dat_i[s*DW +: DW];
    end
    ack_sel = |(s_ack_i & sel_oh);
    err_sel = |(s_err_i & sel_oh);
  end

  // Next state, slave strobes and master response.
  always_comb begin
    state_d  = state_q;
    s_cyc_o  = '0;
    s_stb_o  = '0;
    m_ack_o  = 1'b0;
    m_err_o  = 1'b0;
    m_dat_o  = '0;
    tmo_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (m_cyc_i && m_stb_i) state_d = dec_mapped ? BUSY : DFLT;
      end
      BUSY: begin
        s_cyc_o = sel_oh & {NUM_SLAVES{m_cyc_i}};
        s_stb_o = sel_oh & {NUM_SLAVES{m_stb_i}};
        m_dat_o = dat_sel;
        if (!m_cyc_i) begin
          state_d = IDLE;
        end else if (ack_sel || err_sel) begin
          // A slave response in the deadline cycle beats the timeout.
          m_ack_o = ack_sel;
          m_err_o = err_sel;
          state_d = IDLE;
        end else if (timeout_hit) begin
          m_err_o  = 1'b1;
          tmo_fire = 1'b1;
          state_d  = IDLE;
        end
      end
      DFLT: begin
        if (m_cyc_i) begin
          m_ack_o = DEFAULT_ACK;
          m_err_o = !DEFAULT_ACK;
          if (DEFAULT_ACK) m_dat_o = DEFAULT_DATA;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, registered slave index and per-access timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tmo_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        idx_q   <= dec_idx;
        tmo_cnt <= '0;
      end else if (state_q == BUSY) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

  // Sticky capture of the first error; a clear in the same cycle as a new
  // error still lets that error be captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_valid_o   <= 1'b0;
      err_adr_o     <= '0;
      err_timeout_o <= 1'b0;
    end else begin
      if (err_clr_i) err_valid_o <= 1'b0;
      if (m_err_o && (!err_valid_o || err_clr_i)) begin
        err_valid_o   <= 1'b1;
        err_adr_o     <= m_adr_i;
        err_timeout_o <= tmo_fire;
      end
    end
  end

endmodule

// File: tb/tb_wb_switch_n.sv
// Self-checking bench for wb_switch_n: directed boundary steps followed by
// randomized accesses checked against a region/latency reference model.
module tb_wb_switch_n;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m_adr, m_wdat;
  logic [3:0]  m_sel;
  logic        m_we, m_cyc, m_stb, err_clr;

  logic [31:0] d0_dat, d1_dat_o;
  logic        d0_ack, d0_err, d1_ack_o, d1_err_o;
  logic [95:0] s0_adr, s0_dat, s0_rdat, s1_adr, s1_dat, s1_rdat;
  logic [11:0] s0_sel, s1_sel;
  logic [2:0]  s0_we, s0_cyc, s0_stb, s0_ack, s0_err;
  logic [2:0]  s1_we, s1_cyc, s1_stb, s1_ack, s1_err;
  logic        e0_valid, e0_to, e1_valid, e1_to;
  logic [31:0] e0_adr, e1_adr;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] R_ADDR = {32'h0000_0000, 32'h0100_0000, 32'h0300_0000, 32'h0000_0000};
  localparam logic [127:0] R_MASK = {32'h03E0_0000, 32'h0300_0000, 32'h0300_0000, 32'h03FF_FFFC};
  localparam logic [15:0]  R_SLV  = {4'd2, 4'd1, 4'd0, 4'd0};

  always #5 clk = ~clk;

  wb_switch_n #(
    .NUM_SLAVES(3), .NUM_REGIONS(4), .AW(32), .DW(32),
    .REGION_ADDR(R_ADDR), .REGION_MASK(R_MASK), .REGION_SLAVE(R_SLV),
    .TIMEOUT_CYCLES(8), .DEFAULT_ACK(1'b0), .DEFAULT_DATA(32'hAAAAAAAA)
  ) dut0 (
    .clk(clk), .rst(rst), .m_adr_i(m_adr), .m_dat_i(m_wdat), .m_dat_o(d0_dat),
    .m_sel_i(m_sel), .m_we_i(m_we), .m_cyc_i(m_cyc), .m_stb_i(m_stb),
    .m_ack_o(d0_ack), .m_err_o(d0_err), .s_adr_o(s0_adr), .s_dat_o(s0_dat),
    .s_sel_o(s0_sel), .s_we_o(s0_we), .s_cyc_o(s0_cyc), .s_stb_o(s0_stb),
    .s_dat_i(s0_rdat), .s_ack_i(s0_ack), .s_err_i(s0_err),
    .err_valid_o(e0_valid), .err_adr_o(e0_adr), .err_timeout_o(e0_to),
    .err_clr_i(err_clr)
  );

  wb_switch_n #(
    .NUM_SLAVES(3), .NUM_REGIONS(4), .AW(32), .DW(32),
    .REGION_ADDR(R_ADDR), .REGION_MASK(R_MASK), .REGION_SLAVE(R_SLV),
    .TIMEOUT_CYCLES(8), .DEFAULT_ACK(1'b1), .DEFAULT_DATA(32'hAAAAAAAA)
  ) dut1 (
    .clk(clk), .rst(rst), .m_adr_i(m_adr), .m_dat_i(m_wdat), .m_dat_o(d1_dat_o),
    .m_sel_i(m_sel), .m_we_i(m_we), .m_cyc_i(m_cyc), .m_stb_i(m_stb),
    .m_ack_o(d1_ack_o), .m_err_o(d1_err_o), .s_adr_o(s1_adr), .s_dat_o(s1_dat),
    .s_sel_o(s1_sel), .s_we_o(s1_we), .s_cyc_o(s1_cyc), .s_stb_o(s1_stb),
    .s_dat_i(s1_rdat), .s_ack_i(s1_ack), .s_err_i(s1_err),
    .err_valid_o(e1_valid), .err_adr_o(e1_adr), .err_timeout_o(e1_to),
    .err_clr_i(err_clr)
  );

  // dut1 only serves the default-ack check; its slaves are zero-wait.
  assign s1_ack  = s1_cyc & s1_stb;
  assign s1_err  = '0;
  assign s1_rdat = {3{32'h1234_5678}};

  // Slave models for dut0: respond after wait_n strobed cycles.
  // mode 0 = ack, 1 = err, 2 = never respond.
  int          wait_n[3];
  int          mode[3];
  logic [31:0] sdat[3];
  int          cnt[3];

  always @(posedge clk) begin
    for (int s = 0; s < 3; s++) cnt[s] <= (s0_cyc[s] && s0_stb[s]) ? cnt[s] + 1 : 0;
  end

  always_comb begin
    s0_ack  = '0;
    s0_err  = '0;
    s0_rdat = '0;
    for (int s = 0; s < 3; s++) begin
      s0_rdat[s*32 +: 32] = sdat[s];
      if (s0_cyc[s] && s0_stb[s] && cnt[s] == wait_n[s]) begin
        if (mode[s] == 0) s0_ack[s] = 1'b1;
        else if (mode[s] == 1) s0_err[s] = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference decode: first window whose masked bits equal the base wins.
  function automatic int ref_slave(input logic [31:0] a);
    logic [31:0] b, m;
    logic [3:0]  sl;
    for (int r = 0; r < 4; r++) begin
      b  = R_ADDR[r*32 +: 32];
      m  = R_MASK[r*32 +: 32];
      sl = R_SLV[r*4 +: 4];
      if (((a ^ b) & m) == 32'h0) return (sl < 4'd3) ? int'(sl) : -1;
    end
    return -1;
  endfunction

  int          n_cyc;
  logic        got_ack, got_err;
  logic [31:0] got_dat, wd_c2;
  logic [2:0]  stb_c1, stb_c2, we_c2, cyc_last;
  logic [3:0]  sel_c2;
  logic        d1_ack;
  logic [31:0] d1_dat;

  // One master access; holds the strobe until dut0 responds.
  task automatic access(input logic [31:0] adr, input logic we, input logic [31:0] wd,
                        input logic [3:0] sel, input logic clr_on_resp);
    @(posedge clk); #1;
    m_adr = adr; m_we = we; m_wdat = wd; m_sel = sel; m_cyc = 1'b1; m_stb = 1'b1;
    n_cyc = 0; got_ack = 1'b0; got_err = 1'b0; got_dat = '0;
    while (!got_ack && !got_err && n_cyc < 40) begin
      @(negedge clk);
      n_cyc++;
      if (n_cyc == 1) stb_c1 = s0_stb;
      if (n_cyc == 2) begin
        stb_c2 = s0_stb; we_c2 = s0_we; wd_c2 = s0_dat[63:32]; sel_c2 = s0_sel[7:4];
        d1_ack = d1_ack_o; d1_dat = d1_dat_o;
      end
      got_ack = d0_ack; got_err = d0_err; got_dat = d0_dat; cyc_last = s0_cyc;
    end
    chk("completes", 32'(n_cyc < 40), 32'd1);
    if (clr_on_resp) err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("idle_after", {27'd0, s0_cyc, d0_ack, d0_err}, 32'd0);
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
  endtask

  logic [31:0] ov_adr[3] = '{32'h0000_0000, 32'h0000_0004, 32'h0300_1858};
  int          ov_s[3]   = '{0, 2, 0};

  initial begin
    int          s, r, exp_cyc;
    logic        exp_err, exp_tmo, exp_valid, exp_to_q, we;
    logic [31:0] adr, exp_adr_q;

    rst = 1'b1; m_adr = '0; m_wdat = '0; m_sel = '0; m_we = 1'b0;
    m_cyc = 1'b0; m_stb = 1'b0; err_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin wait_n[i] = 0; mode[i] = 0; sdat[i] = 32'h100 + i; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cyc", {29'd0, s0_cyc}, 32'd0);
    chk("rst_stb", {29'd0, s0_stb}, 32'd0);
    chk("rst_ackerr", {30'd0, d0_ack, d0_err}, 32'd0);
    chk("rst_dat", d0_dat, 32'd0);
    chk("rst_errv", {31'd0, e0_valid}, 32'd0);
    chk("rst_erradr", e0_adr, 32'd0);
    chk("rst_errto", {31'd0, e0_to}, 32'd0);

    // Overlapping windows, zero-wait reads.
    for (int i = 0; i < 3; i++) begin
      sdat[ov_s[i]] = $urandom;
      access(ov_adr[i], 1'b0, 32'd0, 4'hF, 1'b0);
      chk("ov_nostb_c1", {29'd0, stb_c1}, 32'd0);
      chk("ov_stb", {29'd0, stb_c2}, 32'd1 << ov_s[i]);
      chk("ov_ack", {31'd0, got_ack}, 32'd1);
      chk("ov_cycles", n_cyc, 32'd2);
      chk("ov_data", got_dat, sdat[ov_s[i]]);
    end

    // Write to slave 1 with three wait cycles.
    wait_n[1] = 3;
    access(32'h0100_0008, 1'b1, 32'h55, 4'b0001, 1'b0);
    chk("wr_stb", {29'd0, stb_c2}, 32'b010);
    chk("wr_we", {31'd0, we_c2[1]}, 32'd1);
    chk("wr_dat", wd_c2, 32'h55);
    chk("wr_sel", {28'd0, sel_c2}, 32'd1);
    chk("wr_ack", {31'd0, got_ack}, 32'd1);
    chk("wr_cycles", n_cyc, 32'd5);
    wait_n[1] = 0;

    // Unmapped: error on dut0, default ack on dut1.
    access(32'h0200_0000, 1'b0, 32'd0, 4'hF, 1'b0);
    chk("um_err", {30'd0, got_ack, got_err}, 32'b01);
    chk("um_cycles", n_cyc, 32'd2);
    chk("um_errv", {31'd0, e0_valid}, 32'd1);
    chk("um_erradr", e0_adr, 32'h0200_0000);
    chk("um_errto", {31'd0, e0_to}, 32'd0);
    chk("um_d1ack", {31'd0, d1_ack}, 32'd1);
    chk("um_d1dat", d1_dat, 32'hAAAA_AAAA);

    // Clear coinciding with a new error captures the new one.
    access(32'h0200_0004, 1'b0, 32'd0, 4'hF, 1'b1);
    chk("clr_coinc_v", {31'd0, e0_valid}, 32'd1);
    chk("clr_coinc_adr", e0_adr, 32'h0200_0004);

    // Timeouts on slave 2.
    pulse_clr();
    chk("clr_v", {31'd0, e0_valid}, 32'd0);
    mode[2] = 2;
    access(32'h0000_0004, 1'b0, 32'd0, 4'hF, 1'b0);
    chk("to_err", {31'd0, got_err}, 32'd1);
    chk("to_cycles", n_cyc, 32'd9);
    chk("to_cyc_at_err", {29'd0, cyc_last}, 32'b100);
    chk("to_errv", {31'd0, e0_valid}, 32'd1);
    chk("to_erradr", e0_adr, 32'h0000_0004);
    chk("to_errto", {31'd0, e0_to}, 32'd1);
    access(32'h0000_0014, 1'b0, 32'd0, 4'hF, 1'b0);
    chk("to2_err", {31'd0, got_err}, 32'd1);
    chk("to2_keepadr", e0_adr, 32'h0000_0004);
    pulse_clr();
    access(32'h0200_0000, 1'b0, 32'd0, 4'hF, 1'b0);
    chk("recap_adr", e0_adr, 32'h0200_0000);
    chk("recap_to", {31'd0, e0_to}, 32'd0);

    // Ack in the deadline cycle wins over the timeout.
    pulse_clr();
    mode[2] = 0; wait_n[2] = 7;
    access(32'h0000_0004, 1'b0, 32'd0, 4'hF, 1'b0);
    chk("tie_resp", {30'd0, got_ack, got_err}, 32'b10);
    chk("tie_cycles", n_cyc, 32'd9);
    chk("tie_errv", {31'd0, e0_valid}, 32'd0);
    wait_n[2] = 0;

    // Abort: drop cyc in BUSY cycle 2.
    wait_n[0] = 5;
    @(posedge clk); #1 m_adr = 32'h0; m_we = 1'b0; m_cyc = 1'b1; m_stb = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("ab_busy_cyc", {29'd0, s0_cyc}, 32'b001);
    @(posedge clk); #1 m_cyc = 1'b0; m_stb = 1'b0;
    #1;
    chk("ab_cyc_same", {29'd0, s0_cyc, s0_stb[0]}, 32'd0);
    chk("ab_noresp", {30'd0, d0_ack, d0_err}, 32'd0);
    @(negedge clk);
    chk("ab_idle", {27'd0, s0_cyc, d0_ack, d0_err}, 32'd0);
    chk("ab_nocap", {31'd0, e0_valid}, 32'd0);

    // Reset in the middle of a BUSY access.
    access(32'h0200_0000, 1'b0, 32'd0, 4'hF, 1'b0);
    @(posedge clk); #1 m_adr = 32'h0; m_cyc = 1'b1; m_stb = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("mr_busy_cyc", {29'd0, s0_cyc}, 32'b001);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("mr_cyc", {26'd0, s0_cyc, s0_stb}, 32'd0);
    chk("mr_resp", {30'd0, d0_ack, d0_err}, 32'd0);
    chk("mr_dat", d0_dat, 32'd0);
    chk("mr_errv", {31'd0, e0_valid}, 32'd0);
    chk("mr_erradr", e0_adr, 32'd0);
    chk("mr_errto", {31'd0, e0_to}, 32'd0);
    m_cyc = 1'b0; m_stb = 1'b0; rst = 1'b0;
    wait_n[0] = 0;

    // Randomized accesses against the reference model.
    exp_valid = 1'b0; exp_adr_q = '0; exp_to_q = 1'b0;
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < 3; k++) begin
        wait_n[k] = $urandom_range(0, 9);
        r = $urandom_range(0, 9);
        mode[k] = (r < 7) ? 0 : (r < 9) ? 1 : 2;
        sdat[k] = $urandom;
      end
      adr = $urandom;
      case ($urandom_range(0, 3))
        0: adr = adr & 32'h0300_0003;
        1: adr = adr & 32'h0320_001C;
        default: ;
      endcase
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        pulse_clr();
        exp_valid = 1'b0;
      end
      s = ref_slave(adr);
      if (s < 0) begin
        exp_err = 1'b1; exp_cyc = 2; exp_tmo = 1'b0;
      end else if (mode[s] == 2 || wait_n[s] >= 8) begin
        exp_err = 1'b1; exp_cyc = 9; exp_tmo = 1'b1;
      end else begin
        exp_err = (mode[s] == 1); exp_cyc = wait_n[s] + 2; exp_tmo = 1'b0;
      end
      access(adr, we, $urandom, 4'hF, 1'b0);
      chk("rnd_cycles", n_cyc, exp_cyc);
      chk("rnd_resp", {30'd0, got_ack, got_err}, {30'd0, !exp_err, exp_err});
      chk("rnd_stb", {29'd0, stb_c2}, (s < 0) ? 32'd0 : (32'd1 << s));
      if (got_ack && !we) chk("rnd_data", got_dat, sdat[s]);
      if (exp_err && !exp_valid) begin
        exp_valid = 1'b1; exp_adr_q = adr; exp_to_q = exp_tmo;
      end
      chk("rnd_errv", {31'd0, e0_valid}, {31'd0, exp_valid});
      if (exp_valid) begin
        chk("rnd_erradr", e0_adr, exp_adr_q);
        chk("rnd_errto", {31'd0, e0_to}, {31'd0, exp_to_q});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
